// File: rtl/pipe_cache_data_ctrl_pkg.sv
// Shared constants, types and helpers for the pipe_cache_data SRAM controller.
//   DATA_WIDTH  : line width in bits
//   ADDR_WIDTH  : line index width
//   NUM_WMASKS  : byte-enable count
//   s1_t        : read stage-1 state (in-flight read plus held same-cycle write data)
//   merge_bytes : per-byte select between old and new line data
package pipe_cache_data_ctrl_pkg;

   localparam int unsigned DATA_WIDTH = 256;
   localparam int unsigned ADDR_WIDTH = 4;
   localparam int unsigned NUM_WMASKS = DATA_WIDTH / 8;

   typedef logic [DATA_WIDTH-1:0] line_t;
   typedef logic [NUM_WMASKS-1:0] mask_t;
   typedef logic [ADDR_WIDTH-1:0] addr_t;

   typedef struct packed {
      logic  valid;
      logic  fwd;
      mask_t fwd_mask;
      line_t fwd_data;
   } s1_t;

   // Bytes with mask bit set come from new_data, the rest from old_data.
   function automatic line_t merge_bytes(line_t old_data, line_t new_data, mask_t mask);
      line_t res;
      for (int i = 0; i < int'(NUM_WMASKS); i++) begin
         res[8*i +: 8] = mask[i] ? new_data[8*i +: 8] : old_data[8*i +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/pipe_cache_data_ctrl_if.sv
// Bundle of requester-side and macro-side signals of the cache data controller.
//   master : requester plus macro model (drives requests, rd_resp_ready, sram_dout1)
//   slave  : the controller (drives ready/response and all macro strobes)
interface pipe_cache_data_ctrl_if;
   import pipe_cache_data_ctrl_pkg::*;

   // write request
   logic  wr_valid;
   logic  wr_ready;
   addr_t wr_addr;
   line_t wr_data;
   mask_t wr_byte_en;
   // read request
   logic  rd_valid;
   logic  rd_ready;
   addr_t rd_addr;
   // read response
   logic  rd_resp_valid;
   logic  rd_resp_ready;
   line_t rd_resp_data;
   // macro ports
   logic  sram_csb0;
   mask_t sram_wmask0;
   addr_t sram_addr0;
   line_t sram_din0;
   logic  sram_csb1;
   addr_t sram_addr1;
   line_t sram_dout1;

   modport master (
      output wr_valid, wr_addr, wr_data, wr_byte_en,
      output rd_valid, rd_addr, rd_resp_ready, sram_dout1,
      input  wr_ready, rd_ready, rd_resp_valid, rd_resp_data,
      input  sram_csb0, sram_wmask0, sram_addr0, sram_din0, sram_csb1, sram_addr1
   );

   modport slave (
      input  wr_valid, wr_addr, wr_data, wr_byte_en,
      input  rd_valid, rd_addr, rd_resp_ready, sram_dout1,
      output wr_ready, rd_ready, rd_resp_valid, rd_resp_data,
      output sram_csb0, sram_wmask0, sram_addr0, sram_din0, sram_csb1, sram_addr1
   );

endinterface

// File: rtl/pipe_cache_data_ctrl_resp_fifo.sv
// In-order response FIFO for the cache data controller.
//   clk, rst_n    : clock, asynchronous active-low reset (discards all entries, zeroes storage)
//   push_i/data   : enqueue one line
//   pop_i         : dequeue head (ignored when empty)
//   head_valid_o  : FIFO not empty; head_data_o holds the oldest entry
//   count_o       : number of stored entries
// Push and pop in the same cycle are allowed, also when full.
module pipe_cache_data_ctrl_resp_fifo #(
   parameter int unsigned Depth = 2,
   parameter int unsigned Width = 256,
   localparam int unsigned CntW = $clog2(Depth + 1),
   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [Width-1:0] push_data_i,
   input  logic             pop_i,
   output logic             head_valid_o,
   output logic [Width-1:0] head_data_o,
   output logic [CntW-1:0]  count_o
);

   logic [Width-1:0] mem_q [Depth];
   logic [Width-1:0] mem_d [Depth];
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]  count_q, count_d;
   logic             pop;

   function automatic logic [PtrW-1:0] ptr_inc(logic [PtrW-1:0] p);
      return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
   endfunction

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      pop      = pop_i & (count_q != '0);

      // When full, wr_ptr equals rd_ptr; the overwritten slot is the one popped this cycle.
      if (push_i) begin
         mem_d[wr_ptr_q] = push_data_i;
         wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end

      unique case ({push_i, pop})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(Depth); i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign head_valid_o = (count_q != '0);
   assign head_data_o  = mem_q[rd_ptr_q];
   assign count_o      = count_q;

endmodule

// File: rtl/pipe_cache_data_ctrl.sv
// Requester-side controller for the pipe_cache_data SRAM macro (1W/1R, 16 x 256b, byte mask).
//   clk    : clock (macro clk0/clk1 are tied to it outside this block)
//   rst_n  : asynchronous active-low reset
//   bus    : slave side of pipe_cache_data_ctrl_if -- write/read requests, read responses
//            and every macro port (csb0/wmask0/addr0/din0, csb1/addr1/dout1)
// Writes go straight to port 0. Reads go to port 1; dout1 is captured one cycle later (S1)
// into a response FIFO. A write fired in the same cycle as a read to the same line is
// merged into that read's response at capture time.
module pipe_cache_data_ctrl
   import pipe_cache_data_ctrl_pkg::*;
#(
   parameter int unsigned RESP_DEPTH = 2
) (
   input logic                   clk,
   input logic                   rst_n,
   pipe_cache_data_ctrl_if.slave bus
);

   localparam int unsigned CntW = $clog2(RESP_DEPTH + 1);

   logic            wr_fire;
   logic            rd_fire;
   logic            deq;
   logic [CntW-1:0] fifo_count;
   logic [CntW:0]   occupancy;
   s1_t             s1_q, s1_d;
   line_t           capture_data;

   always_comb begin
      bus.wr_ready = rst_n;
      wr_fire      = bus.wr_valid & bus.wr_ready;
      deq          = bus.rd_resp_valid & bus.rd_resp_ready;

      // Credit: FIFO entries plus the read already in S1, minus the entry leaving now.
      // S1 can then always push, so the read pipe never stalls.
      occupancy    = {1'b0, fifo_count} + {{CntW{1'b0}}, s1_q.valid} - {{CntW{1'b0}}, deq};
      bus.rd_ready = rst_n & (occupancy < (CntW + 1)'(RESP_DEPTH));
      rd_fire      = bus.rd_valid & bus.rd_ready;

      s1_d       = '0;
      s1_d.valid = rd_fire;
      // Same-cycle write reaches the macro one edge too late for this read; hold it in S1.
      if (rd_fire && wr_fire && (bus.wr_addr == bus.rd_addr)) begin
         s1_d.fwd      = 1'b1;
         s1_d.fwd_mask = bus.wr_byte_en;
         s1_d.fwd_data = bus.wr_data;
      end

      capture_data = s1_q.fwd ? merge_bytes(bus.sram_dout1, s1_q.fwd_data, s1_q.fwd_mask)
                              : bus.sram_dout1;

      bus.sram_csb0   = ~wr_fire;
      bus.sram_wmask0 = bus.wr_byte_en;
      bus.sram_addr0  = bus.wr_addr;
      bus.sram_din0   = bus.wr_data;
      bus.sram_csb1   = ~rd_fire;
      bus.sram_addr1  = bus.rd_addr;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q <= '0;
      end else begin
         s1_q <= s1_d;
      end
   end

   pipe_cache_data_ctrl_resp_fifo #(
      .Depth (RESP_DEPTH),
      .Width (DATA_WIDTH)
   ) u_resp_fifo (
      .clk          (clk),
      .rst_n        (rst_n),
      .push_i       (s1_q.valid),
      .push_data_i  (capture_data),
      .pop_i        (bus.rd_resp_ready),
      .head_valid_o (bus.rd_resp_valid),
      .head_data_o  (bus.rd_resp_data),
      .count_o      (fifo_count)
   );

endmodule
